// File: rtl/cdb_broadcaster_pkg.sv
// cdb_broadcaster_pkg: shared ROB/CDB sizing, packet types and ROB age helpers.
package cdb_broadcaster_pkg;
  localparam int ROB_SZ = 8;
  localparam int TAG_W = 4;
  localparam int XLEN = 32;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0] v;
    logic branch_mispredicted;
    logic [XLEN-1:0] branch_loc;
  } FU_CDB_PACKET;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0] v;
    logic branch_mispredicted;
    logic [XLEN-1:0] branch_loc;
  } CDB_ROB_PACKET;
  function automatic int age(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] h);
    return (int'(t) + ROB_SZ - int'(h)) % ROB_SZ;
  endfunction
  function automatic logic younger(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] br,
                                   input logic [TAG_W-1:0] h);
    return age(t, h) > age(br, h);
  endfunction
endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus winner index.
module rr_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PW = NUM_FU > 1 ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [PW-1:0]     winner,
  output logic              any
);
  always_comb begin
    winner = '0;
    for (int k = NUM_FU - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_FU]) winner = PW'((int'(ptr) + k) % NUM_FU);
  end
  assign any = |req;
  assign grant = any ? NUM_FU'(1) << winner : '0;
endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: per-FU holding slots, round-robin CDB broadcast with branch squash.
// Define CDB_PERF_EN to add saturating busy/conflict cycle counters.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_FU-1:0]      fu_valid,
  output logic [NUM_FU-1:0]      fu_ready,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0] fu_value,
  input  logic [NUM_FU-1:0]      fu_branch_mispredicted,
  input  logic [NUM_FU*XLEN-1:0] fu_branch_loc,
  input  logic [TAG_W-1:0]       rob_head,
  input  logic                   branch_valid,
  input  logic [TAG_W-1:0]       branch_rob_tag,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [XLEN-1:0]        cdb_value,
  output logic                   cdb_branch_mispredicted,
  output logic [XLEN-1:0]        cdb_branch_loc
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]            cdb_busy_cycles,
  output logic [31:0]            cdb_conflict_cycles
`endif
);
  localparam int PW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
  FU_CDB_PACKET hold [NUM_FU];
  FU_CDB_PACKET hold_n [NUM_FU];
  FU_CDB_PACKET fu_in [NUM_FU];
  CDB_ROB_PACKET cdb, cdb_n;
  logic [PW-1:0] rr_ptr, rr_ptr_n, winner;
  logic [NUM_FU-1:0] req, grant;
  logic any, win_ok;
  rr_arbiter #(.NUM_FU(NUM_FU), .PW(PW)) u_arb (
    .req(req), .ptr(rr_ptr), .grant(grant), .winner(winner), .any(any)
  );
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      req[i] = hold[i].valid;
      fu_in[i] = '{valid: fu_valid[i], rob_tag: fu_tag[i*TAG_W +: TAG_W],
                   v: fu_value[i*XLEN +: XLEN], branch_mispredicted: fu_branch_mispredicted[i],
                   branch_loc: fu_branch_loc[i*XLEN +: XLEN]};
    end
  end
  assign fu_ready = ~req | grant;
  // A squashed winner is not broadcast and does not move the pointer.
  assign win_ok = any && !(branch_valid && younger(hold[winner].rob_tag, branch_rob_tag, rob_head));
  always_comb begin
    cdb_n = win_ok ? CDB_ROB_PACKET'(hold[winner]) : '0;
    rr_ptr_n = win_ok ? PW'((int'(winner) + 1) % NUM_FU) : rr_ptr;
    for (int i = 0; i < NUM_FU; i++) begin
      hold_n[i] = hold[i];
      if (fu_valid[i] && fu_ready[i])
        hold_n[i] = (fu_in[i].rob_tag != '0 &&
                     !(branch_valid && younger(fu_in[i].rob_tag, branch_rob_tag, rob_head))) ? fu_in[i] : '0;
      else if (grant[i] || (branch_valid && younger(hold[i].rob_tag, branch_rob_tag, rob_head)))
        hold_n[i] = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      hold <= '{default: '0};
      rr_ptr <= '0;
      cdb <= '0;
    end else begin
      hold <= hold_n;
      rr_ptr <= rr_ptr_n;
      cdb <= cdb_n;
    end
  end
  assign cdb_valid = cdb.valid;
  assign cdb_tag = cdb.rob_tag;
  assign cdb_value = cdb.v;
  assign cdb_branch_mispredicted = cdb.branch_mispredicted;
  assign cdb_branch_loc = cdb.branch_loc;
`ifdef CDB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_busy_cycles <= '0;
      cdb_conflict_cycles <= '0;
    end else begin
      if (cdb_n.valid && ~&cdb_busy_cycles) cdb_busy_cycles <= cdb_busy_cycles + 32'd1;
      if ($countones(req) > 1 && ~&cdb_conflict_cycles) cdb_conflict_cycles <= cdb_conflict_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster: directed scenarios plus randomized run against a slot-level reference model.
module tb_cdb_broadcaster;
  logic clock = 0, reset = 1;
  logic [3:0] fu_valid, fu_ready, fu_bm;
  logic [15:0] fu_tag;
  logic [127:0] fu_value, fu_loc;
  logic [3:0] rob_head, branch_rob_tag;
  logic branch_valid;
  logic cdb_valid, cdb_bm;
  logic [3:0] cdb_tag;
  logic [31:0] cdb_value, cdb_loc;
`ifdef CDB_PERF_EN
  logic [31:0] busy_cycles, conflict_cycles;
`endif
  int tests = 0, fails = 0;

  cdb_broadcaster dut (
    .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag),
    .fu_value(fu_value), .fu_branch_mispredicted(fu_bm), .fu_branch_loc(fu_loc),
    .rob_head(rob_head), .branch_valid(branch_valid), .branch_rob_tag(branch_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_branch_mispredicted(cdb_bm), .cdb_branch_loc(cdb_loc)
`ifdef CDB_PERF_EN
    , .cdb_busy_cycles(busy_cycles), .cdb_conflict_cycles(conflict_cycles)
`endif
  );

  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic idle_inputs;
    fu_valid = '0; fu_tag = '0; fu_value = '0; fu_bm = '0; fu_loc = '0;
    rob_head = 4'd1; branch_valid = 0; branch_rob_tag = '0;
  endtask
  task automatic do_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask
  task automatic put(input int i, input int tag, input logic [31:0] val);
    fu_valid[i] = 1'b1;
    fu_tag[i*4 +: 4] = 4'(tag);
    fu_value[i*32 +: 32] = val;
    fu_bm[i] = val[0];
    fu_loc[i*32 +: 32] = ~val;
  endtask

  function automatic int mage(input int t, input int h);
    return (t - h + 8) % 8;
  endfunction

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d want 0", cdb_valid); end
    reset = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %0d want 0", cdb_valid); end
      tests++; if (cdb_tag !== 4'd0) begin fails++; $display("FAIL idle_tag got %0d want 0", cdb_tag); end
      tests++; if (fu_ready !== 4'b1111) begin fails++; $display("FAIL idle_ready got %b want 1111", fu_ready); end
    end
  endtask

  task automatic test_single;
    do_reset();
    put(1, 3, 32'hDEAD);
    tick();
    fu_valid = '0;
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL single_edge0 got %0d want 0", cdb_valid); end
    tick();
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3) begin fails++; $display("FAIL single_tag got %0d/%0d want 1/3", cdb_valid, cdb_tag); end
    tests++; if (cdb_value !== 32'hDEAD) begin fails++; $display("FAIL single_value got %h want dead", cdb_value); end
    tests++; if (cdb_bm !== 1'b1 || cdb_loc !== ~32'hDEAD) begin fails++; $display("FAIL single_branch got %0d/%h want 1/%h", cdb_bm, cdb_loc, ~32'hDEAD); end
    tick();
    tests++; if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0) begin fails++; $display("FAIL single_edge2 got %0d/%0d want 0/0", cdb_valid, cdb_tag); end
  endtask

  task automatic test_contention;
    do_reset();
    for (int i = 0; i < 4; i++) put(i, i + 1, 32'h100 + i);
    tick();
    fu_valid = '0;
    tests++; if (fu_ready[3] !== 1'b0) begin fails++; $display("FAIL cont_ready3_pre got %0d want 0", fu_ready[3]); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'(k)) begin fails++; $display("FAIL cont_tag got %0d/%0d want 1/%0d", cdb_valid, cdb_tag, k); end
      tests++; if (cdb_value !== 32'h100 + k - 1) begin fails++; $display("FAIL cont_value got %h want %h", cdb_value, 32'h100 + k - 1); end
      tests++; if (fu_ready[3] !== (k >= 3)) begin fails++; $display("FAIL cont_ready3 got %0d want %0d", fu_ready[3], k >= 3); end
    end
    tick();
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL cont_drain got %0d want 0", cdb_valid); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    put(0, 2, 32'hA2);
    tick();
    put(0, 5, 32'hA5);
    #1;
    tests++; if (fu_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready got %0d want 1", fu_ready[0]); end
    tick();
    fu_valid = '0;
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2) begin fails++; $display("FAIL b2b_first got %0d/%0d want 1/2", cdb_valid, cdb_tag); end
    tick();
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd5 || cdb_value !== 32'hA5) begin fails++; $display("FAIL b2b_second got %0d/%0d/%h want 1/5/a5", cdb_valid, cdb_tag, cdb_value); end
    tick();
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %0d want 0", cdb_valid); end
  endtask

  task automatic test_squash_wrap;
    do_reset();
    rob_head = 4'd7;
    put(0, 8, 32'h88); put(1, 1, 32'h11); put(2, 6, 32'h66);
    tick();
    fu_valid = '0;
    branch_valid = 1; branch_rob_tag = 4'd8;
    put(3, 2, 32'h22);
    #1;
    tests++; if (fu_ready[3] !== 1'b1) begin fails++; $display("FAIL squash_in_ready got %0d want 1", fu_ready[3]); end
    tick();
    fu_valid = '0; branch_valid = 0;
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd8) begin fails++; $display("FAIL squash_keep got %0d/%0d want 1/8", cdb_valid, cdb_tag); end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++; if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0) begin fails++; $display("FAIL squash_leak got %0d/%0d want 0/0", cdb_valid, cdb_tag); end
    end
    tests++; if (fu_ready !== 4'b1111) begin fails++; $display("FAIL squash_ready got %b want 1111", fu_ready); end
    rob_head = 4'd1;
    put(1, 3, 32'h33);
    tick();
    fu_valid = '0;
    branch_valid = 1; branch_rob_tag = 4'd2;
    tick();
    branch_valid = 0;
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL squash_winner got %0d want 0", cdb_valid); end
    tests++; if (fu_ready !== 4'b1111) begin fails++; $display("FAIL squash_winner_ready got %b want 1111", fu_ready); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    put(0, 4, 32'h44); put(1, 5, 32'h55); put(2, 6, 32'h66);
    tick();
    fu_valid = '0;
    reset = 1;
    tick();
    reset = 0;
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %0d want 0", cdb_valid); end
    tests++; if (fu_ready !== 4'b1111) begin fails++; $display("FAIL rmid_ready got %b want 1111", fu_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL rmid_leak got %0d/%0d want 0", cdb_valid, cdb_tag); end
    end
  endtask

  task automatic test_random;
    bit mv[4];
    int mt[4];
    logic [31:0] mval[4], mloc[4];
    bit mbm[4];
    int mptr = 0;
    do_reset();
    for (int i = 0; i < 4; i++) mv[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int w, ev, et, brt, rh;
      logic [31:0] eval, eloc;
      bit ebm, killw;
      bit rdy[4];
      logic [3:0] erdy;
      fu_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        fu_tag[i*4 +: 4] = ($urandom % 10 == 0) ? 4'd0 : 4'($urandom_range(1, 8));
        fu_value[i*32 +: 32] = $urandom;
        fu_loc[i*32 +: 32] = $urandom;
        fu_bm[i] = 1'($urandom);
      end
      rh = $urandom_range(1, 8);
      brt = $urandom_range(1, 8);
      rob_head = 4'(rh);
      branch_rob_tag = 4'(brt);
      branch_valid = ($urandom % 5 == 0);
      #1;
      w = -1;
      for (int k = 0; k < 4; k++) if (w < 0 && mv[(mptr + k) % 4]) w = (mptr + k) % 4;
      for (int i = 0; i < 4; i++) begin
        rdy[i] = !mv[i] || i == w;
        erdy[i] = rdy[i];
      end
      tests++; if (fu_ready !== erdy) begin fails++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, fu_ready, erdy); end
      killw = branch_valid && w >= 0 && mage(mt[w], rh) > mage(brt, rh);
      if (w >= 0 && !killw) begin
        ev = 1; et = mt[w]; eval = mval[w]; ebm = mbm[w]; eloc = mloc[w];
        mptr = (w + 1) % 4;
      end else begin
        ev = 0; et = 0; eval = 0; ebm = 0; eloc = 0;
      end
      for (int i = 0; i < 4; i++) begin
        int t = int'(fu_tag[i*4 +: 4]);
        if (fu_valid[i] && rdy[i]) begin
          mv[i] = t != 0 && !(branch_valid && mage(t, rh) > mage(brt, rh));
          mt[i] = t; mval[i] = fu_value[i*32 +: 32]; mbm[i] = fu_bm[i]; mloc[i] = fu_loc[i*32 +: 32];
        end else if (i == w || (branch_valid && mv[i] && mage(mt[i], rh) > mage(brt, rh))) mv[i] = 0;
      end
      tick();
      tests++; if (cdb_valid !== 1'(ev) || cdb_tag !== 4'(et)) begin fails++; $display("FAIL rand_tag cyc %0d got %0d/%0d want %0d/%0d", cyc, cdb_valid, cdb_tag, ev, et); end
      tests++; if (cdb_value !== eval || cdb_bm !== ebm || cdb_loc !== eloc) begin fails++; $display("FAIL rand_data cyc %0d got %h/%0d/%h want %h/%0d/%h", cyc, cdb_value, cdb_bm, cdb_loc, eval, ebm, eloc); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_squash_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer end of the completion bus that the reorder buffer, reservation stations and map table consume.
- Collects results from NUM_FU functional units, each through a one-entry holding slot with valid/ready handshake.
- Round-robin arbitrates among the slots and broadcasts one registered result per cycle as a CDB_ROB_PACKET-compatible bundle.
- Discards results younger than a resolving mispredicted branch.

Parameters:
- NUM_FU, 4, number of functional-unit completion ports.
- ROB_SZ, 8, ROB entries; valid tags are 1..ROB_SZ, tag 0 means "no broadcast".
- TAG_W, 4, ROB tag width; must hold ROB_SZ.
- XLEN, 32, data and branch-target width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_ready  out  NUM_FU  per-FU slot can accept this cycle.
- fu_tag  in  NUM_FU*TAG_W  ROB tag of each result.
- fu_value  in  NUM_FU*XLEN  result value.
- fu_branch_mispredicted  in  NUM_FU  result is a mispredicted branch.
- fu_branch_loc  in  NUM_FU*XLEN  corrected branch target.
- rob_head  in  TAG_W  current ROB head tag, used for age compare.
- branch_valid  in  1  squash request this cycle.
- branch_rob_tag  in  TAG_W  tag of the mispredicted branch; it is kept, younger tags are killed.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast ROB tag; 0 when cdb_valid=0.
- cdb_value  out  XLEN  broadcast value.
- cdb_branch_mispredicted  out  1  broadcast mispredict flag.
- cdb_branch_loc  out  XLEN  broadcast branch target.

Behaviour:
- Reset (synchronous, priority over everything):
  - all hold_valid=0 and rr_ptr=0.
  - all cdb_* outputs 0.
  - fu_ready all 1 in the cycle after reset deasserts.
  - Reset mid-operation drops every pending result.
- Handshake:
  - fu_ready[i] = !hold_valid[i] || grant[i]. It is combinational and does not depend on fu_valid.
  - A transfer occurs when fu_valid[i] && fu_ready[i] at a rising edge. The slot then loads tag, value, mispredict and loc.
  - A tag of 0 with fu_valid=1 is accepted but never broadcast; the slot clears at that edge.
- Arbitration:
  - grant is one-hot over hold_valid only, never over the raw fu_valid inputs.
  - Priority search starts at rr_ptr and wraps modulo NUM_FU.
  - On a grant, rr_ptr becomes (winner+1) mod NUM_FU; otherwise rr_ptr holds.
  - A granted slot clears at the edge unless refilled by a simultaneous transfer.
- Output register, updated every edge:
  - cdb_* take the winner's fields, with cdb_valid=1.
  - With no winner: cdb_valid=0 and all fields 0.
  - Latency: a result accepted at edge N appears on the CDB at edge N+1 at best. With NUM_FU contending slots, the worst case is edge N+NUM_FU.
- Age: age(t) = (t - rob_head + ROB_SZ) mod ROB_SZ over tags 1..ROB_SZ. Tag t is younger than the branch iff age(t) > age(branch_rob_tag).
- Squash, when branch_valid is high:
  - Every hold slot with a younger tag clears at that edge.
  - An incoming transfer with a younger tag is dropped. Ready is still asserted, so the FU completes its handshake.
  - If the current winner is younger, the output register loads cdb_valid=0 and the grant is not consumed; rr_ptr does not advance.
  - The branch's own result and older results are unaffected.
- Simultaneous events on one slot: a grant and a new transfer in the same cycle give broadcast of the old result plus capture of the new one. A squash on the incoming result wins over capture.

Optional Feature:
- Macro: CDB_PERF_EN.
- When defined, two extra outputs are added:
  - cdb_busy_cycles (32 bits): increments on every edge where cdb_valid is loaded with 1.
  - cdb_conflict_cycles (32 bits): increments when more than one hold_valid is set.
- Both counters reset to 0 and saturate at 2^32-1.
- When undefined, the ports and counters do not exist and all other behaviour is identical.

Decomposition:
- Add FU_CDB_PACKET typedef (valid, rob_tag, v, branch_mispredicted, branch_loc) to sys_defs.
- Output is driven as the existing CDB_ROB_PACKET.
- ROB_SZ and TAG_W come from the shared defines.
- Sub-module rr_arbiter: parameterised NUM_FU. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and the winner index. It is purely combinational. The pointer register lives in cdb_broadcaster.

Test Plan:
- Reset then idle: cdb_valid=0, cdb_tag=0, fu_ready=4'b1111 for 5 cycles.
- Single result: FU1 sends tag 3, value 0xDEAD at edge 0 -> cdb_tag=3, value=0xDEAD at edge 1; cdb_valid=0 at edge 2.
- Contention: all 4 FUs send tags 1..4 in the same cycle with rr_ptr=0 -> broadcasts tags 1,2,3,4 on 4 consecutive edges. fu_ready[3] stays 0 until its grant cycle.
- Back-to-back refill: FU0 holds tag 2 and is granted while presenting tag 5 -> tag 2 is broadcast, then tag 5 next edge, with no bubble.
- Squash with wrap: rob_head=7, slots hold tags 8, 1 and 6, branch_rob_tag=8 -> tag 8 is kept and broadcast; tags 1 and 6 are discarded and never appear on the CDB.
- Reset mid-contention: 3 slots full, then reset pulse -> the next cycle has cdb_valid=0, all ready=1, and none of the old tags are ever broadcast.
